// File: rtl/instr_buffer.sv
// instr_buffer: dual-lane FWFT instruction FIFO between fetch and decode.
// Optional perf counters are built only when IB_PERF_COUNTER_EN is defined.
module instr_buffer #(
    parameter int IF_WIDTH     = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int BUFFER_SIZE  = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic                                stall_i,
    input  logic [IF_WIDTH-1:0]                 if_valid_i,
    input  logic [IF_WIDTH-1:0][31:0]           if_pc_i,
    input  logic [IF_WIDTH-1:0][31:0]           if_instr_i,
    input  logic [IF_WIDTH-1:0]                 if_excp_i,
    output logic                                if_ready_o,
    output logic [DECODE_WIDTH-1:0]             id_valid_o,
    output logic [DECODE_WIDTH-1:0][31:0]       id_pc_o,
    output logic [DECODE_WIDTH-1:0][31:0]       id_instr_o,
    output logic [DECODE_WIDTH-1:0]             id_excp_o,
    input  logic [DECODE_WIDTH-1:0]             id_accept_i,
    output logic [31:0]                         perf_empty_cnt_o,
    output logic [31:0]                         perf_full_cnt_o
);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d, push_n, pop_n;
    logic [IF_WIDTH-1:0][PW-1:0]  wr_idx;
    logic                         push_en, pop_run;
    logic [31:0]                  pc_q    [BUFFER_SIZE];
    logic [31:0]                  instr_q [BUFFER_SIZE];
    logic                         excp_q  [BUFFER_SIZE];

    assign if_ready_o = (CW'(BUFFER_SIZE) - count_q) >= CW'(IF_WIDTH);
    assign push_en    = if_ready_o && !flush_i;

    // Valid lanes are packed in lane order; pops stop at the first unaccepted slot.
    always_comb begin
        push_n  = '0;
        for (int i = 0; i < IF_WIDTH; i++) begin
            wr_idx[i] = tail_q + PW'(push_n);
            push_n    = push_n + CW'(if_valid_i[i]);
        end
        push_n  = push_en ? push_n : '0;
        pop_n   = '0;
        pop_run = !stall_i && !flush_i;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            pop_run = pop_run && id_accept_i[k] && id_valid_o[k];
            pop_n   = pop_n + CW'(pop_run);
        end
        head_d  = flush_i ? '0 : head_q + PW'(pop_n);
        tail_d  = flush_i ? '0 : tail_q + PW'(push_n);
        count_d = flush_i ? '0 : count_q + push_n - pop_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IF_WIDTH; i++) begin
            if (push_en && if_valid_i[i]) begin
                pc_q[wr_idx[i]]    <= if_pc_i[i];
                instr_q[wr_idx[i]] <= if_instr_i[i];
                excp_q[wr_idx[i]]  <= if_excp_i[i];
            end
        end
    end

    genvar d;
    generate
        for (d = 0; d < DECODE_WIDTH; d++) begin : g_rd
            logic [PW-1:0] rd_idx;
            assign rd_idx        = head_q + PW'(d);
            assign id_valid_o[d] = count_q > CW'(d);
            assign id_pc_o[d]    = pc_q[rd_idx];
            assign id_instr_o[d] = instr_q[rd_idx];
            assign id_excp_o[d]  = excp_q[rd_idx];
        end
    endgenerate

`ifdef IB_PERF_COUNTER_EN
    logic [31:0] empty_cnt_q, empty_cnt_d, full_cnt_q, full_cnt_d;

    assign empty_cnt_d = empty_cnt_q + 32'((count_q == '0) && !(&empty_cnt_q));
    assign full_cnt_d  = full_cnt_q + 32'(!if_ready_o && (|if_valid_i) && !(&full_cnt_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            empty_cnt_q <= empty_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign perf_empty_cnt_o = empty_cnt_q;
    assign perf_full_cnt_o  = full_cnt_q;
`else
    assign perf_empty_cnt_o = 32'h0;
    assign perf_full_cnt_o  = 32'h0;
`endif
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: queue-model scoreboard for instr_buffer, directed scenarios plus random traffic.
module tb_instr_buffer;
    localparam int SIZE = 8;

    logic             clk = 0, rst_n = 0, flush = 0, stall = 0;
    logic [1:0]       if_valid = 0, if_excp = 0, id_valid, id_excp, acc = 0;
    logic [1:0][31:0] if_pc = 0, if_instr = 0, id_pc, id_instr;
    logic             if_ready;
    logic [31:0]      perf_empty, perf_full;

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic excp; } ent_t;
    ent_t             q[$];
    logic [31:0]      m_empty = 0, m_full = 0;
    int               vectors = 0, errors = 0, seq = 0, sz, n;

    instr_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .stall_i(stall),
        .if_valid_i(if_valid), .if_pc_i(if_pc), .if_instr_i(if_instr), .if_excp_i(if_excp),
        .if_ready_o(if_ready), .id_valid_o(id_valid), .id_pc_o(id_pc), .id_instr_o(id_instr),
        .id_excp_o(id_excp), .id_accept_i(acc),
        .perf_empty_cnt_o(perf_empty), .perf_full_cnt_o(perf_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] a, input logic s, input logic f);
        if_valid = v; acc = a; stall = s; flush = f;
        for (int i = 0; i < 2; i++) begin
            if_pc[i]    = 32'h1c00_0000 + 32'(4 * seq);
            if_instr[i] = $urandom;
            if_excp[i]  = 1'($urandom_range(0, 1));
            if (v[i]) seq++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: accepted lanes appended to the expected queue, pops taken from its front.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_empty = 0;
            m_full  = 0;
        end else begin
            sz = q.size();
            if (sz == 0 && m_empty != 32'hFFFF_FFFF) m_empty++;
            if (sz > SIZE - 2 && if_valid != 0 && m_full != 32'hFFFF_FFFF) m_full++;
            if (flush) q.delete();
            else begin
                n = stall ? 0 : (acc[0] ? (acc[1] ? 2 : 1) : 0);
                if (n > sz) n = sz;
                repeat (n) void'(q.pop_front());
                if (sz <= SIZE - 2)
                    for (int i = 0; i < 2; i++)
                        if (if_valid[i]) q.push_back('{if_pc[i], if_instr[i], if_excp[i]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("id_valid[%0d]", k), 64'(id_valid[k]), 64'(q.size() > k));
                if (q.size() > k) begin
                    chk($sformatf("id_pc[%0d]", k), 64'(id_pc[k]), 64'(q[k].pc));
                    chk($sformatf("id_instr[%0d]", k), 64'(id_instr[k]), 64'(q[k].instr));
                    chk($sformatf("id_excp[%0d]", k), 64'(id_excp[k]), 64'(q[k].excp));
                end
            end
            chk("if_ready", 64'(if_ready), 64'(q.size() <= SIZE - 2));
`ifdef IB_PERF_COUNTER_EN
            chk("perf_empty", 64'(perf_empty), 64'(m_empty));
            chk("perf_full", 64'(perf_full), 64'(m_full));
`else
            chk("perf_empty", 64'(perf_empty), 64'h0);
            chk("perf_full", 64'(perf_full), 64'h0);
`endif
        end
    end

    initial begin
        logic [1:0] a;
        int r;
        drv(2'b00, 2'b00, 0, 0);
        #1;
        chk("reset id_valid", 64'(id_valid), 64'h0);
        chk("reset if_ready", 64'(if_ready), 64'h1);
        tick();
        tick();
        rst_n = 1;
        repeat (10) tick();
`ifdef IB_PERF_COUNTER_EN
        chk("perf_empty idle10", 64'(perf_empty), 64'd10);
`else
        chk("perf_empty idle10", 64'(perf_empty), 64'd0);
`endif
        seq = 0;
        drv(2'b11, 2'b00, 0, 0);
        tick();
        chk("first push valid", 64'(id_valid), 64'h3);
        chk("first push pc0", 64'(id_pc[0]), 64'h1c00_0000);
        chk("first push pc1", 64'(id_pc[1]), 64'h1c00_0004);
        repeat (3) begin
            drv(2'b11, 2'b00, 0, 0);
            tick();
        end
        chk("full ready", 64'(if_ready), 64'h0);
        drv(2'b11, 2'b00, 0, 0);
        repeat (3) tick();
`ifdef IB_PERF_COUNTER_EN
        chk("perf_full 3", 64'(perf_full), 64'd3);
`else
        chk("perf_full 3", 64'(perf_full), 64'd0);
`endif
        drv(2'b00, 2'b01, 0, 0);
        tick();
        chk("count7 ready", 64'(if_ready), 64'h0);
        drv(2'b00, 2'b11, 0, 0);
        tick();
        chk("count5 ready", 64'(if_ready), 64'h1);
        drv(2'b00, 2'b01, 0, 0);
        tick();
        drv(2'b11, 2'b11, 1, 0);
        tick();
        chk("stall head pc", 64'(id_pc[0]), 64'h1c00_0010);
        chk("stall ready", 64'(if_ready), 64'h1);
        drv(2'b11, 2'b11, 0, 1);
        tick();
        chk("flush id_valid", 64'(id_valid), 64'h0);
        drv(2'b11, 2'b00, 0, 0);
        tick();
        tick();
        drv(2'b01, 2'b00, 0, 0);
        tick();
        drv(2'b00, 2'b00, 0, 0);
        #1;
        rst_n = 0;
        #1;
        chk("async rst id_valid", 64'(id_valid), 64'h0);
        chk("async rst if_ready", 64'(if_ready), 64'h1);
        tick();
        rst_n = 1;
        seq = 64;
        drv(2'b01, 2'b00, 0, 0);
        tick();
        chk("post rst slot0 pc", 64'(id_pc[0]), 64'h1c00_0100);
        chk("post rst valid", 64'(id_valid), 64'h1);
        repeat (1500) begin
            r = $urandom_range(0, 9);
            a = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            drv(2'($urandom_range(0, 3)), a, $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
            tick();
        end
        drv(2'b00, 2'b00, 0, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
